// File: rtl/fp32_dot_accumulator_if.sv
// Product-stream / writeback handshake bundle for fp32_dot_accumulator.
// The o_nan/o_inexact flags exist only when FPACC_FLAGS_EN is defined.
interface fp32_dot_accumulator_if;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_data;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_sum;
  logic        o_overflow;
`ifdef FPACC_FLAGS_EN
  logic        o_nan;
  logic        o_inexact;
`endif

  modport slave (
    input  i_valid, i_data, i_ready,
    output o_ready, o_valid, o_sum, o_overflow
`ifdef FPACC_FLAGS_EN
    , output o_nan, o_inexact
`endif
  );

  modport master (
    output i_valid, i_data, i_ready,
    input  o_ready, o_valid, o_sum, o_overflow
`ifdef FPACC_FLAGS_EN
    , input o_nan, o_inexact
`endif
  );
endinterface

// File: rtl/fp32_dot_accumulator.sv
// Sums N_TERMS fp32 products into one dot-product element using a multi-cycle adder FSM.
// Optional sticky o_nan/o_inexact outputs are enabled by defining FPACC_FLAGS_EN.
module fp32_dot_accumulator #(
  parameter int unsigned N_TERMS = 4,
  parameter int unsigned CNT_W   = $clog2(N_TERMS + 1)
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  fp32_dot_accumulator_if.slave        bus
);

  localparam logic [31:0] QNAN = 32'h7fc0_0000;

  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_OUT} state_t;

  state_t             r_state;
  logic [31:0]        r_acc, r_op, r_sum, r_spec_val;
  logic [CNT_W-1:0]   r_count;
  logic               r_ready, r_valid, r_ovf, r_special, r_sign, r_sub;
  logic signed [9:0]  r_exp;
  logic [27:0]        r_big, r_small, r_mag;
`ifdef FPACC_FLAGS_EN
  logic               r_nan, r_inexact;
`endif

  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] n;
    n = 5'd27;
    for (int i = 0; i < 27; i++) if (v[i]) n = 5'(26 - i);
    return n;
  endfunction

  // ALIGN: operand classification and special-case result
  logic w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan, w_special;
  logic [31:0] w_spec_val;
  assign w_a_zero = (r_acc[30:23] == 8'd0);
  assign w_b_zero = (r_op[30:23] == 8'd0);
  assign w_a_inf  = (r_acc[30:23] == 8'hff) && (r_acc[22:0] == 23'd0);
  assign w_b_inf  = (r_op[30:23] == 8'hff) && (r_op[22:0] == 23'd0);
  assign w_a_nan  = (r_acc[30:23] == 8'hff) && (r_acc[22:0] != 23'd0);
  assign w_b_nan  = (r_op[30:23] == 8'hff) && (r_op[22:0] != 23'd0);

  always_comb begin
    w_special  = 1'b1;
    w_spec_val = QNAN;
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (r_acc[31] != r_op[31]))) w_spec_val = QNAN;
    else if (w_a_inf)               w_spec_val = r_acc;
    else if (w_b_inf)               w_spec_val = r_op;
    else if (w_a_zero && w_b_zero)  w_spec_val = {r_acc[31] & r_op[31], 31'd0};
    else if (w_a_zero)              w_spec_val = r_op;
    else if (w_b_zero)              w_spec_val = r_acc;
    else                            w_special  = 1'b0;
  end

  // ALIGN: order by magnitude, shift the smaller significand with sticky collection
  logic        w_swap;
  logic [31:0] w_big;
  logic [30:0] w_small;
  logic [7:0]  w_diff;
  logic [4:0]  w_sh;
  logic [55:0] w_small_wide;
  logic [27:0] w_small_al;
  assign w_swap       = (r_op[30:0] > r_acc[30:0]);
  assign w_big        = w_swap ? r_op : r_acc;
  assign w_small      = w_swap ? r_acc[30:0] : r_op[30:0];
  assign w_diff       = w_big[30:23] - w_small[30:23];
  assign w_sh         = (w_diff > 8'd27) ? 5'd27 : w_diff[4:0];
  assign w_small_wide = {2'b01, w_small[22:0], 3'b000, 28'd0} >> w_sh;
  assign w_small_al   = {w_small_wide[55:29], w_small_wide[28] | (|w_small_wide[27:0])};

  // NORM: carry shift-right or leading-zero shift-left
  logic [4:0]        w_lz;
  logic signed [9:0] w_exp_lz;
  assign w_lz     = lzc27(r_mag[26:0]);
  assign w_exp_lz = r_exp - $signed({5'd0, w_lz});

  // ROUND: round-to-nearest-even and overflow to infinity
  logic [23:0]       w_mant;
  logic              w_g, w_rs, w_up, w_ovf;
  logic [24:0]       w_mant_r;
  logic [22:0]       w_frac;
  logic signed [9:0] w_exp_r;
  logic [31:0]       w_res;
  assign w_mant   = r_mag[26:3];
  assign w_g      = r_mag[2];
  assign w_rs     = r_mag[1] | r_mag[0];
  assign w_up     = w_g & (w_rs | w_mant[0]);
  assign w_mant_r = {1'b0, w_mant} + 25'(w_up);
  assign w_frac   = w_mant_r[24] ? w_mant_r[23:1] : w_mant_r[22:0];
  assign w_exp_r  = w_mant_r[24] ? (r_exp + 10'sd1) : r_exp;
  assign w_ovf    = (w_exp_r >= 10'sd255);
  assign w_res    = r_special ? r_spec_val
                  : (w_ovf ? {r_sign, 8'hff, 23'd0} : {r_sign, w_exp_r[7:0], w_frac});

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_acc      <= 32'd0;
      r_op       <= 32'd0;
      r_sum      <= 32'd0;
      r_spec_val <= 32'd0;
      r_count    <= '0;
      r_ready    <= 1'b0;
      r_valid    <= 1'b0;
      r_ovf      <= 1'b0;
      r_special  <= 1'b0;
      r_sign     <= 1'b0;
      r_sub      <= 1'b0;
      r_exp      <= 10'sd0;
      r_big      <= 28'd0;
      r_small    <= 28'd0;
      r_mag      <= 28'd0;
`ifdef FPACC_FLAGS_EN
      r_nan      <= 1'b0;
      r_inexact  <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ready <= 1'b1;
          if (bus.i_valid && r_ready) begin
            r_op    <= bus.i_data;
            r_count <= r_count + CNT_W'(1);
            r_ready <= 1'b0;
            r_state <= S_ALIGN;
          end
        end
        S_ALIGN: begin
          r_special  <= w_special;
          r_spec_val <= w_spec_val;
          r_sign     <= w_big[31];
          r_exp      <= $signed({2'b00, w_big[30:23]});
          r_big      <= {2'b01, w_big[22:0], 3'b000};
          r_small    <= w_small_al;
          r_sub      <= r_acc[31] ^ r_op[31];
          r_state    <= w_special ? S_ROUND : S_ADD;
        end
        S_ADD: begin
          r_mag   <= r_sub ? (r_big - r_small) : (r_big + r_small);
          r_state <= S_NORM;
        end
        S_NORM: begin
          // Exact cancellation yields +0; exponent underflow flushes to signed zero
          if (r_mag == 28'd0) begin
            r_special  <= 1'b1;
            r_spec_val <= 32'd0;
          end else if (r_mag[27]) begin
            r_mag <= {1'b0, r_mag[27:2], r_mag[1] | r_mag[0]};
            r_exp <= r_exp + 10'sd1;
          end else begin
            if (w_exp_lz <= 10'sd0) begin
              r_special  <= 1'b1;
              r_spec_val <= {r_sign, 31'd0};
            end
            r_mag <= r_mag << w_lz;
            r_exp <= w_exp_lz;
          end
          r_state <= S_ROUND;
        end
        S_ROUND: begin
          r_acc <= w_res;
          if (!r_special && w_ovf) r_ovf <= 1'b1;
`ifdef FPACC_FLAGS_EN
          if ((w_res[30:23] == 8'hff) && (w_res[22:0] != 23'd0)) r_nan <= 1'b1;
          if (!r_special && (w_g || w_rs)) r_inexact <= 1'b1;
`endif
          if (r_count == CNT_W'(N_TERMS)) begin
            r_sum   <= w_res;
            r_valid <= 1'b1;
            r_state <= S_OUT;
          end else begin
            r_ready <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        S_OUT: begin
          if (bus.i_ready) begin
            r_acc     <= 32'd0;
            r_count   <= '0;
            r_ovf     <= 1'b0;
            r_valid   <= 1'b0;
            r_ready   <= 1'b1;
`ifdef FPACC_FLAGS_EN
            r_nan     <= 1'b0;
            r_inexact <= 1'b0;
`endif
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_ready    = r_ready;
  assign bus.o_valid    = r_valid;
  assign bus.o_sum      = r_sum;
  assign bus.o_overflow = r_ovf;
`ifdef FPACC_FLAGS_EN
  assign bus.o_nan      = r_nan;
  assign bus.o_inexact  = r_inexact;
`endif

endmodule

// File: tb/tb_fp32_dot_accumulator.sv
// Directed scoreboard bench for fp32_dot_accumulator (N_TERMS=4).
// Flag checks are compiled in when FPACC_FLAGS_EN is defined.
module tb_fp32_dot_accumulator;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic [31:0] sum;
    logic        ovf;
    logic        nan;
    logic        inexact;
  } exp_t;

  exp_t sb_q[$];

  fp32_dot_accumulator_if bus();

  fp32_dot_accumulator #(.N_TERMS(4)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one term and hold it until the accepting edge
  task automatic send(input logic [31:0] d);
    int n;
    n = 0;
    while (!bus.o_ready && n < 50) begin step(); n++; end
    chk("ready_wait", 32'(bus.o_ready), 32'd1);
    bus.i_valid = 1'b1;
    bus.i_data  = d;
    step();
    bus.i_valid = 1'b0;
  endtask

  task automatic push(input logic [31:0] s, input logic o, input logic nn, input logic ix);
    exp_t e;
    e.sum = s; e.ovf = o; e.nan = nn; e.inexact = ix;
    sb_q.push_back(e);
  endtask

  // Wait for a result, compare against the scoreboard head, then accept it
  task automatic collect(input string tag);
    int   n;
    exp_t e;
    n = 0;
    while (!bus.o_valid && n < 100) begin step(); n++; end
    chk({tag, "_valid"}, 32'(bus.o_valid), 32'd1);
    chk({tag, "_sb"}, 32'(sb_q.size() != 0), 32'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk({tag, "_sum"}, bus.o_sum, e.sum);
      chk({tag, "_ovf"}, 32'(bus.o_overflow), 32'(e.ovf));
`ifdef FPACC_FLAGS_EN
      chk({tag, "_nan"}, 32'(bus.o_nan), 32'(e.nan));
      chk({tag, "_inexact"}, 32'(bus.o_inexact), 32'(e.inexact));
`endif
    end
    chk({tag, "_no_ready"}, 32'(bus.o_ready), 32'd0);
    bus.i_ready = 1'b1;
    step();
    bus.i_ready = 1'b0;
    chk({tag, "_valid_clr"}, 32'(bus.o_valid), 32'd0);
    chk({tag, "_ovf_clr"}, 32'(bus.o_overflow), 32'd0);
`ifdef FPACC_FLAGS_EN
    chk({tag, "_nan_clr"}, 32'(bus.o_nan), 32'd0);
    chk({tag, "_inexact_clr"}, 32'(bus.o_inexact), 32'd0);
`endif
  endtask

  initial begin
    logic [31:0] held;
    rst         = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b0;
    bus.i_data  = 32'd0;
    #1 rst = 1'b1;
    #2;
    chk("rst_ready", 32'(bus.o_ready), 32'd0);
    chk("rst_valid", 32'(bus.o_valid), 32'd0);
    chk("rst_sum", bus.o_sum, 32'd0);
    chk("rst_ovf", 32'(bus.o_overflow), 32'd0);
    step(); step();
    chk("rst_ready_held", 32'(bus.o_ready), 32'd0);
    rst = 1'b0;

    // 2 + 3 + 1.5 - 4.25 = 2.25, with latency checks on the last term
    push(32'h4010_0000, 1'b0, 1'b0, 1'b0);
    send(32'h4000_0000);
    chk("ready_drop", 32'(bus.o_ready), 32'd0);
    send(32'h4040_0000);
    send(32'h3fc0_0000);
    send(32'hc088_0000);
    step(); step(); step();
    chk("lat_not_yet", 32'(bus.o_valid), 32'd0);
    step();
    chk("lat_valid", 32'(bus.o_valid), 32'd1);
    collect("mix");

    // Exact cancellation then zeros gives +0
    push(32'h0000_0000, 1'b0, 1'b0, 1'b0);
    send(32'h40c0_0000);
    send(32'hc0c0_0000);
    send(32'h0000_0000);
    send(32'h0000_0000);
    collect("cancel");

    // inf + 1 + (-inf) + 1 -> canonical NaN
    push(32'h7fc0_0000, 1'b0, 1'b1, 1'b0);
    send(32'h7f80_0000);
    send(32'h3f80_0000);
    send(32'hff80_0000);
    send(32'h3f80_0000);
    collect("nan");

    // max + max overflows to +inf
    push(32'h7f80_0000, 1'b1, 1'b0, 1'b0);
    send(32'h7f7f_ffff);
    send(32'h7f7f_ffff);
    send(32'h0000_0000);
    send(32'h0000_0000);
    collect("ovf");

    // Stall in OUT with a pending term: result stable, nothing consumed
    push(32'h4040_0000, 1'b0, 1'b0, 1'b0);
    send(32'h3f80_0000);
    send(32'h3f80_0000);
    send(32'h3f80_0000);
    send(32'h0000_0000);
    for (int i = 0; i < 100 && !bus.o_valid; i++) step();
    held = bus.o_sum;
    bus.i_valid = 1'b1;
    bus.i_data  = 32'h4100_0000;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("hold_sum", bus.o_sum, 32'h4040_0000);
      chk("hold_ready", 32'(bus.o_ready), 32'd0);
    end
    chk("hold_stable", bus.o_sum, held);
    bus.i_valid = 1'b0;
    collect("hold");

    // Next element starts from +0
    push(32'h4040_0000, 1'b0, 1'b0, 1'b0);
    send(32'h3f80_0000);
    send(32'h4000_0000);
    send(32'h0000_0000);
    send(32'h0000_0000);
    collect("fresh");

    // Asynchronous reset after two terms discards the partial sum
    send(32'h4000_0000);
    send(32'h4000_0000);
    #2 rst = 1'b1;
    #1;
    chk("arst_ready", 32'(bus.o_ready), 32'd0);
    chk("arst_valid", 32'(bus.o_valid), 32'd0);
    chk("arst_sum", bus.o_sum, 32'd0);
    chk("arst_ovf", 32'(bus.o_overflow), 32'd0);
    step(); step();
    rst = 1'b0;
    push(32'h4080_0000, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send(32'h3f80_0000);
    collect("post_rst");

    // 1 + 2^-24 rounds to 1.0 on a tie-to-even
    push(32'h3f80_0000, 1'b0, 1'b0, 1'b1);
    send(32'h3f80_0000);
    send(32'h3380_0000);
    send(32'h0000_0000);
    send(32'h0000_0000);
    collect("inexact");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
